// File: rtl/pif_pkg.sv
// Shared constants, command codes and slot state type for the PIF RAM controller.
package pif_pkg;

    localparam int               ADDR_W        = 9;
    localparam logic [8:0]       ROM_WORDS     = 9'd496;
    localparam logic [8:0]       CMD_WORD      = 9'd511;
    localparam logic [10:0]      CMD_BYTE_ADDR = 11'h7FF;

    // Command bits found in the PIF command byte
    localparam logic [7:0]       CMD_JOYBUS    = 8'h01;
    localparam logic [7:0]       CMD_CHALLENGE = 8'h02;
    localparam logic [7:0]       CMD_TERMINATE = 8'h08;
    localparam logic [7:0]       CMD_LOCK_ROM  = 8'h10;
    localparam logic [7:0]       CMD_ACK       = 8'h20;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_WAIT = 1'b1
    } slot_state_t;

    // Byte 0 of a word is the most significant byte (bits [31:24]).
    function automatic logic [3:0] byte_lane_en(input logic [1:0] byte_sel);
        return 4'b1000 >> byte_sel;
    endfunction

    function automatic logic [7:0] byte_pick(input logic [31:0] word, input logic [1:0] byte_sel);
        logic [7:0] result;
        case (byte_sel)
            2'd0:    result = word[31:24];
            2'd1:    result = word[23:16];
            2'd2:    result = word[15:8];
            default: result = word[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pif_ram_dp.sv
// 512x32 PIF memory: port A is a registered read port for the N64 side,
// port B is a registered read/write port with byte enables. Reads that
// hit the address being written on the same cycle return the new bytes.
module pif_ram_dp #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [31:0]       a_q,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [3:0]        b_be,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];
    logic [31:0] a_raw;
    logic [31:0] b_raw;
    logic [31:0] a_fwd;
    logic [31:0] b_fwd;
    logic        addr_hit;

    assign a_raw    = mem[a_addr];
    assign b_raw    = mem[b_addr];
    assign addr_hit = (a_addr == b_addr);

    // Per-lane write-first forwarding for both read ports
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign a_fwd[gi*8 +: 8] = (b_we && b_be[gi] && addr_hit) ? b_wdata[gi*8 +: 8] : a_raw[gi*8 +: 8];
            assign b_fwd[gi*8 +: 8] = (b_we && b_be[gi])             ? b_wdata[gi*8 +: 8] : b_raw[gi*8 +: 8];
        end
    endgenerate

    // Byte-enabled write; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (b_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b_be[i]) begin
                    mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Port A output register, refreshed every cycle
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            a_q <= 32'h0;
        end else begin
            a_q <= a_fwd;
        end
    end

    // Port B output register, only refreshed when the port is used
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            b_q <= 32'h0;
        end else if (b_en) begin
            b_q <= b_fwd;
        end
    end

endmodule

// File: rtl/pif_ram_controller.sv
// PIF memory arbitration: N64 word port has absolute priority, the CPU byte
// port uses a one-entry slot that waits for a cycle without an N64 write.
// Also latches PIF command bytes written by the N64.
module pif_ram_controller
    import pif_pkg::*;
#(
    parameter int               ADDR_W    = pif_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] ROM_WORDS = pif_pkg::ROM_WORDS,
    parameter logic [ADDR_W-1:0] CMD_WORD  = pif_pkg::CMD_WORD
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [ADDR_W-1:0] n64_address,
    input  logic              n64_wren,
    input  logic [31:0]       n64_data_in,
    output logic [31:0]       n64_data_out,
    input  logic [10:0]       cpu_address,
    input  logic              cpu_wren,
    input  logic              cpu_oe,
    input  logic [7:0]        cpu_data_in,
    output logic [7:0]        cpu_data_out,
    output logic              cpu_valid,
    input  logic              rom_lock,
    output logic              cmd_pending,
    output logic [7:0]        cmd_byte
);

    slot_state_t       slot_state_reg;
    logic [10:0]       slot_addr_reg;
    logic [7:0]        slot_data_reg;
    logic              slot_write_reg;
    logic              valid_reg;
    logic              valid_read_reg;
    logic [1:0]        valid_sel_reg;
    logic              hide_reg;
    logic              cmd_pending_reg;
    logic [7:0]        cmd_byte_reg;

    logic              n64_write_ok;
    logic              cpu_grant;
    logic              cmd_write;
    logic              cmd_clear;
    logic              b_en;
    logic              b_we;
    logic [3:0]        b_be;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_wdata;
    logic [31:0]       a_q;
    logic [31:0]       b_q;

    // ROM-region N64 writes are silently dropped but still stall the CPU
    assign n64_write_ok = n64_wren && (n64_address >= ROM_WORDS);
    assign cpu_grant    = (slot_state_reg == SLOT_WAIT) && !n64_wren;

    assign cmd_write = n64_wren && (n64_address == CMD_WORD) && (n64_data_in[7:0] != 8'h00);
    assign cmd_clear = cpu_grant && slot_write_reg && (slot_addr_reg == CMD_BYTE_ADDR)
                       && (slot_data_reg == 8'h00);

    // Port B is shared: N64 writes own it whenever n64_wren is high
    assign b_en    = n64_wren || cpu_grant;
    assign b_we    = n64_write_ok || (cpu_grant && slot_write_reg);
    assign b_be    = n64_wren ? 4'hF : byte_lane_en(slot_addr_reg[1:0]);
    assign b_addr  = n64_wren ? n64_address : slot_addr_reg[10:2];
    assign b_wdata = n64_wren ? n64_data_in : {4{slot_data_reg}};

    pif_ram_dp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_l (reset_l),
        .a_addr  (n64_address),
        .a_q     (a_q),
        .b_en    (b_en),
        .b_we    (b_we),
        .b_be    (b_be),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_q     (b_q)
    );

    // Remember whether the word now being read must be hidden by the ROM lock
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            hide_reg <= 1'b0;
        end else begin
            hide_reg <= rom_lock && (n64_address < ROM_WORDS);
        end
    end

    assign n64_data_out = hide_reg ? 32'h0 : a_q;

    // CPU request slot: latch in IDLE, wait for a free port-B cycle, then complete
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            slot_state_reg <= SLOT_IDLE;
            slot_addr_reg  <= 11'h0;
            slot_data_reg  <= 8'h0;
            slot_write_reg <= 1'b0;
            valid_reg      <= 1'b0;
            valid_read_reg <= 1'b0;
            valid_sel_reg  <= 2'd0;
        end else begin
            valid_reg <= 1'b0;
            case (slot_state_reg)
                SLOT_IDLE: begin
                    if (cpu_wren || cpu_oe) begin
                        slot_addr_reg  <= cpu_address;
                        slot_data_reg  <= cpu_data_in;
                        slot_write_reg <= cpu_wren;
                        slot_state_reg <= SLOT_WAIT;
                    end
                end
                SLOT_WAIT: begin
                    // New requests here are dropped, including one on the grant cycle
                    if (!n64_wren) begin
                        valid_reg      <= 1'b1;
                        valid_read_reg <= !slot_write_reg;
                        valid_sel_reg  <= slot_addr_reg[1:0];
                        slot_state_reg <= SLOT_IDLE;
                    end
                end
                default: slot_state_reg <= SLOT_IDLE;
            endcase
        end
    end

    // Read byte is taken straight from the port-B output register on the valid cycle
    assign cpu_valid    = valid_reg;
    assign cpu_data_out = (valid_reg && valid_read_reg) ? byte_pick(b_q, valid_sel_reg) : 8'h00;

    // Command latch: N64 sets it, a granted CPU write of zero to the command byte clears it
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            cmd_pending_reg <= 1'b0;
            cmd_byte_reg    <= 8'h00;
        end else if (cmd_write) begin
            cmd_pending_reg <= 1'b1;
            cmd_byte_reg    <= n64_data_in[7:0];
        end else if (cmd_clear) begin
            cmd_pending_reg <= 1'b0;
        end
    end

    assign cmd_pending = cmd_pending_reg;
    assign cmd_byte    = cmd_byte_reg;

endmodule

// File: tb/tb_pif_ram_controller.sv
// Scoreboard bench for pif_ram_controller: stimulus pushes expectations,
// a negedge monitor pops and compares them when the DUT presents data.
module tb_pif_ram_controller;

    logic        clk = 1'b0;
    logic        reset_l;
    logic [8:0]  n64_address;
    logic        n64_wren;
    logic [31:0] n64_data_in;
    logic [31:0] n64_data_out;
    logic [10:0] cpu_address;
    logic        cpu_wren;
    logic        cpu_oe;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_valid;
    logic        rom_lock;
    logic        cmd_pending;
    logic [7:0]  cmd_byte;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } cpu_exp_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } probe_t;

    cpu_exp_t    cpu_q[$];
    logic [31:0] n64_q[$];
    probe_t      probe_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic n64_rd_strobe = 1'b0;
    logic rd_chk = 1'b0;
    logic end_req = 1'b0;

    pif_ram_controller dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .n64_address  (n64_address),
        .n64_wren     (n64_wren),
        .n64_data_in  (n64_data_in),
        .n64_data_out (n64_data_out),
        .cpu_address  (cpu_address),
        .cpu_wren     (cpu_wren),
        .cpu_oe       (cpu_oe),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_valid    (cpu_valid),
        .rom_lock     (rom_lock),
        .cmd_pending  (cmd_pending),
        .cmd_byte     (cmd_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_chk <= n64_rd_strobe;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] probe_val(input int sel);
        case (sel)
            0:       return n64_data_out;
            1:       return {24'h0, cpu_data_out};
            2:       return {31'h0, cpu_valid};
            3:       return {31'h0, cmd_pending};
            default: return {24'h0, cmd_byte};
        endcase
    endfunction

    // Monitor: all comparisons happen here, away from the active edge
    cpu_exp_t    m_cpu;
    logic [31:0] m_word;
    probe_t      m_probe;
    always @(negedge clk) begin
        if (rd_chk) begin
            tests++;
            if (n64_q.size() == 0) begin
                fails++;
                $display("FAIL n64_read: got %08h with no expectation queued", n64_data_out);
            end else begin
                m_word = n64_q.pop_front();
                if (n64_data_out !== m_word) begin
                    fails++;
                    $display("FAIL n64_read: got %08h expected %08h", n64_data_out, m_word);
                end else
                    $display("[TB] n64 read  data=%08h ok", n64_data_out);
            end
        end
        if (cpu_valid === 1'b1) begin
            tests++;
            if (cpu_q.size() == 0) begin
                fails++;
                $display("FAIL cpu_valid: got unexpected pulse (data %02h) expected none", cpu_data_out);
            end else begin
                m_cpu = cpu_q.pop_front();
                if (cpu_data_out !== m_cpu.data || (m_cpu.cyc >= 0 && cyc != m_cpu.cyc)) begin
                    fails++;
                    $display("FAIL cpu_access: got data %02h at cycle %0d expected %02h at cycle %0d",
                             cpu_data_out, cyc, m_cpu.data, m_cpu.cyc);
                end else
                    $display("[TB] cpu done  data=%02h cycle=%0d ok", cpu_data_out, cyc);
            end
        end
        while (probe_q.size() > 0) begin
            m_probe = probe_q.pop_front();
            tests++;
            if (probe_val(m_probe.sel) !== m_probe.exp) begin
                fails++;
                $display("FAIL %s: got %0h expected %0h", m_probe.name, probe_val(m_probe.sel), m_probe.exp);
            end else
                $display("[TB] probe %s = %0h ok", m_probe.name, m_probe.exp);
        end
        if (end_req) begin
            tests = tests + cpu_q.size() + n64_q.size();
            fails = fails + cpu_q.size() + n64_q.size();
            if (cpu_q.size() + n64_q.size() != 0)
                $display("FAIL leftover: got %0d outstanding expectations expected 0",
                         cpu_q.size() + n64_q.size());
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int sel, input logic [31:0] exp, input string name);
        probe_t p;
        p.sel  = sel;
        p.exp  = exp;
        p.name = name;
        probe_q.push_back(p);
    endtask

    task automatic n64_rd(input logic [8:0] a, input logic [31:0] exp);
        n64_address   = a;
        n64_rd_strobe = 1'b1;
        n64_q.push_back(exp);
        tick();
        n64_rd_strobe = 1'b0;
    endtask

    task automatic n64_wr(input logic [8:0] a, input logic [31:0] d);
        n64_address = a;
        n64_data_in = d;
        n64_wren    = 1'b1;
        tick();
        n64_wren    = 1'b0;
    endtask

    task automatic cpu_issue(input logic wr, input logic [10:0] a, input logic [7:0] d, input logic [7:0] exp);
        cpu_exp_t e;
        e.data      = exp;
        e.cyc       = -1;
        cpu_address = a;
        cpu_data_in = d;
        cpu_wren    = wr;
        cpu_oe      = !wr;
        cpu_q.push_back(e);
        tick();
        cpu_wren = 1'b0;
        cpu_oe   = 1'b0;
    endtask

    task automatic cpu_wait();
        for (int i = 0; i < 40 && cpu_q.size() != 0; i++) tick();
        tick();
    endtask

    initial begin
        int c0;
        cpu_exp_t e;
        reset_l = 1'b0; n64_address = '0; n64_wren = 1'b0; n64_data_in = '0;
        cpu_address = '0; cpu_wren = 1'b0; cpu_oe = 1'b0; cpu_data_in = '0; rom_lock = 1'b0;
        tick(); tick();
        probe(0, 32'h0, "reset_n64_data_out");
        probe(1, 32'h0, "reset_cpu_data_out");
        probe(2, 32'h0, "reset_cpu_valid");
        probe(3, 32'h0, "reset_cmd_pending");
        probe(4, 32'h0, "reset_cmd_byte");
        tick();
        reset_l = 1'b1;
        tick();

        // 1: CPU loads boot bytes, N64 reads with and without ROM lock
        cpu_issue(1'b1, 11'h000, 8'hDE, 8'h00); cpu_wait();
        cpu_issue(1'b1, 11'h001, 8'hAD, 8'h00); cpu_wait();
        cpu_issue(1'b1, 11'h002, 8'hBE, 8'h00); cpu_wait();
        cpu_issue(1'b1, 11'h003, 8'hEF, 8'h00); cpu_wait();
        n64_rd(9'd0, 32'hDEADBEEF);
        rom_lock = 1'b1;
        n64_rd(9'd0, 32'h0);
        cpu_issue(1'b0, 11'h002, 8'h00, 8'hBE); cpu_wait();
        rom_lock = 1'b0;

        // 2: N64 writes into ROM are dropped; RAM region takes full words
        cpu_issue(1'b1, 11'h028, 8'h5A, 8'h00); cpu_wait();
        n64_wr(9'd10, 32'h12345678);
        cpu_issue(1'b0, 11'h028, 8'h00, 8'h5A); cpu_wait();
        cpu_issue(1'b1, 11'h7BC, 8'h77, 8'h00); cpu_wait();
        n64_wr(9'd495, 32'hFFFFFFFF);
        cpu_issue(1'b0, 11'h7BC, 8'h00, 8'h77); cpu_wait();
        n64_wr(9'd500, 32'hCAFEF00D);
        rom_lock = 1'b1;
        n64_rd(9'd500, 32'hCAFEF00D);
        rom_lock = 1'b0;
        cpu_issue(1'b0, 11'h7D3, 8'h00, 8'h0D); cpu_wait();

        // 3: command detect, zero write, overwrite, CPU clear
        probe(3, 32'h0, "cmd_pending_idle");
        n64_wr(9'd511, 32'h00000001);
        probe(3, 32'h1, "cmd_pending_set");
        probe(4, 32'h01, "cmd_byte_set");
        n64_wr(9'd511, 32'h00000000);
        probe(3, 32'h1, "cmd_pending_zero_write");
        n64_wr(9'd511, 32'h00000008);
        probe(3, 32'h1, "cmd_pending_overwrite");
        probe(4, 32'h08, "cmd_byte_overwrite");
        cpu_issue(1'b1, 11'h7FF, 8'h00, 8'h00);
        probe(3, 32'h1, "cmd_pending_grant_cycle");
        tick();
        probe(3, 32'h0, "cmd_pending_cleared");
        cpu_wait();

        // 4: CPU read stalled behind a 16-word N64 burst
        for (int i = 0; i < 16; i++) begin
            n64_wren    = 1'b1;
            n64_address = 9'(496 + i);
            n64_data_in = {8'(8'hC0 + i), 8'h11, 8'h22, 8'h00};
            if (i == 2) begin
                c0          = cyc;
                cpu_oe      = 1'b1;
                cpu_address = 11'h7C0;
                e.data      = 8'hC0;
                e.cyc       = c0 + 15;
                cpu_q.push_back(e);
            end
            tick();
            cpu_oe = 1'b0;
        end
        n64_wren = 1'b0;
        cpu_wait();
        n64_rd(9'd511, 32'hCF112200);

        // 5a: a second request while waiting is dropped
        n64_address = 9'd0; n64_data_in = 32'hFFFFFFFF; n64_wren = 1'b1;
        cpu_issue(1'b0, 11'h000, 8'h00, 8'hDE);
        tick();
        cpu_oe = 1'b1; cpu_address = 11'h001;
        tick();
        cpu_oe = 1'b0;
        tick();
        n64_wren = 1'b0;
        cpu_wait();
        repeat (6) tick();

        // 5b: reset while waiting discards the request
        n64_wr(9'd511, 32'h00000010);
        probe(3, 32'h1, "cmd_pending_before_reset");
        probe(4, 32'h10, "cmd_byte_before_reset");
        n64_address = 9'd0; n64_data_in = 32'h0; n64_wren = 1'b1;
        cpu_oe = 1'b1; cpu_address = 11'h002;
        tick();
        cpu_oe = 1'b0;
        tick();
        reset_l = 1'b0;
        tick();
        probe(0, 32'h0, "rst_wait_n64_data_out");
        probe(1, 32'h0, "rst_wait_cpu_data_out");
        probe(2, 32'h0, "rst_wait_cpu_valid");
        probe(3, 32'h0, "rst_wait_cmd_pending");
        probe(4, 32'h0, "rst_wait_cmd_byte");
        tick();
        reset_l  = 1'b1;
        n64_wren = 1'b0;
        repeat (10) tick();
        probe(3, 32'h0, "cmd_pending_after_reset");
        n64_rd(9'd0, 32'hDEADBEEF);
        tick();
        end_req = 1'b1;
        tick();
    end

endmodule
